// File: rtl/kronos_mem_arbiter.sv
// kronos_mem_arbiter: shares one memory port between the Kronos fetch and load/store interfaces.
// Define KRONOS_ARB_RR_EN for round-robin arbitration instead of data priority with starvation guard.
module kronos_mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rstz,
  input  logic [31:0] instr_addr,
  input  logic        instr_req,
  output logic        instr_ack,
  output logic [31:0] instr_data,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wr_data,
  input  logic [3:0]  data_mask,
  input  logic        data_wr_en,
  input  logic        data_req,
  output logic        data_ack,
  output logic [31:0] data_rd_data,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wr_data,
  output logic [3:0]  mem_mask,
  output logic        mem_wr_en,
  output logic        mem_req,
  input  logic        mem_ack,
  input  logic [31:0] mem_rd_data
);

  typedef enum logic [1:0] {IDLE = 2'd0, GNT_I = 2'd1, GNT_D = 2'd2} state_t;

  state_t      state_reg, state_next;
  logic        pick_data;
  logic        pick_instr;
  logic [31:0] addr_reg;
  logic [31:0] wr_data_reg;
  logic [3:0]  mask_reg;
  logic        wr_en_reg;

`ifdef KRONOS_ARB_RR_EN
  // last_gnt_reg: 0 = instr, 1 = data; on a tie the other side wins
  logic last_gnt_reg;

  assign pick_data = data_req && (!instr_req || !last_gnt_reg);

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      last_gnt_reg <= 1'b0;
    end else if (state_reg == IDLE && (data_req || instr_req)) begin
      last_gnt_reg <= pick_data;
    end
  end
`else
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt_reg;

  assign pick_data = data_req && !(instr_req && starve_cnt_reg >= STARVE_MAX);

  // Counts data grants taken while a fetch was waiting
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      starve_cnt_reg <= 4'd0;
    end else if (state_reg == IDLE) begin
      if (!instr_req) begin
        starve_cnt_reg <= 4'd0;
      end else if (pick_data) begin
        if (starve_cnt_reg != 4'hF) begin
          starve_cnt_reg <= starve_cnt_reg + 4'd1;
        end
      end else begin
        starve_cnt_reg <= 4'd0;
      end
    end
  end
`endif

  assign pick_instr = instr_req && !pick_data;

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (pick_data) begin
          state_next = GNT_D;
        end else if (pick_instr) begin
          state_next = GNT_I;
        end
      end
      GNT_I, GNT_D: begin
        if (mem_ack) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Request fields are captured once at grant so mem_* stays stable until mem_ack
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      addr_reg    <= 32'd0;
      wr_data_reg <= 32'd0;
      mask_reg    <= 4'd0;
      wr_en_reg   <= 1'b0;
    end else if (state_reg == IDLE) begin
      if (pick_data) begin
        addr_reg    <= data_addr;
        wr_data_reg <= data_wr_data;
        mask_reg    <= data_mask;
        wr_en_reg   <= data_wr_en;
      end else if (pick_instr) begin
        addr_reg    <= instr_addr;
        wr_data_reg <= 32'd0;
        mask_reg    <= 4'hF;
        wr_en_reg   <= 1'b0;
      end
    end
  end

  assign mem_addr    = addr_reg;
  assign mem_wr_data = wr_data_reg;
  assign mem_mask    = mask_reg;
  assign mem_wr_en   = wr_en_reg;
  assign mem_req     = (state_reg != IDLE);

  always_comb begin
    instr_ack    = 1'b0;
    data_ack     = 1'b0;
    instr_data   = 32'd0;
    data_rd_data = 32'd0;
    if (mem_ack) begin
      case (state_reg)
        GNT_I: begin
          instr_ack  = 1'b1;
          instr_data = mem_rd_data;
        end
        GNT_D: begin
          data_ack     = 1'b1;
          data_rd_data = mem_rd_data;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_kronos_mem_arbiter.sv
// Scoreboard bench for kronos_mem_arbiter: a reference arbiter predicts each grant,
// a memory-side monitor compares grants and acks against it.
`timescale 1ns/1ps
module tb_kronos_mem_arbiter;

  localparam int STARVE_LIMIT = 4;

  logic        clk = 1'b0;
  logic        rstz = 1'b0;
  logic [31:0] instr_addr = 32'd0;
  logic        instr_req = 1'b0;
  logic        instr_ack;
  logic [31:0] instr_data;
  logic [31:0] data_addr = 32'd0;
  logic [31:0] data_wr_data = 32'd0;
  logic [3:0]  data_mask = 4'd0;
  logic        data_wr_en = 1'b0;
  logic        data_req = 1'b0;
  logic        data_ack;
  logic [31:0] data_rd_data;
  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic [3:0]  mem_mask;
  logic        mem_wr_en;
  logic        mem_req;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rd_data = 32'd0;

  kronos_mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rstz(rstz),
    .instr_addr(instr_addr), .instr_req(instr_req), .instr_ack(instr_ack), .instr_data(instr_data),
    .data_addr(data_addr), .data_wr_data(data_wr_data), .data_mask(data_mask),
    .data_wr_en(data_wr_en), .data_req(data_req), .data_ack(data_ack), .data_rd_data(data_rd_data),
    .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_mask(mem_mask), .mem_wr_en(mem_wr_en),
    .mem_req(mem_req), .mem_ack(mem_ack), .mem_rd_data(mem_rd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_data;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    bit          wr;
  } txn_t;

  txn_t        exp_q[$];
  bit          side_log[$];   // 1 = data served, 0 = instr served (from the DUT's acks)
  logic [31:0] data_log[$];
  int          grant_cyc[$];
  int          ack_cyc[$];

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int req_cyc = 0;

  int instr_mode = 0;       // 0 quiet, 1 random, 2 always re-request
  int data_mode = 0;
  int mem_lat = 1;          // -1 = random 0..3
  bit rd_override_en = 1'b0;
  logic [31:0] rd_override = 32'd0;
  bit mem_auto = 1'b1;
  bit model_en = 1'b1;

  bit   busy = 1'b0;
  int   starve = 0;
  bit   last_data = 1'b0;
  bit   in_txn = 1'b0;
  bit   ack_driven = 1'b0;
  bit   cur_valid = 1'b0;
  int   wait_left = 0;
  txn_t cur;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic clear_logs();
    side_log.delete();
    data_log.delete();
    grant_cyc.delete();
    ack_cyc.delete();
  endtask

  task automatic wait_quiet(input string name, input int budget);
    int c;
    c = 0;
    while ((instr_req || data_req || mem_req || busy || in_txn || exp_q.size() != 0) && c < budget) begin
      @(negedge clk);
      c++;
    end
    n_checks++;
    if (c >= budget) begin
      n_fail++;
      $display("FAIL %s: still busy after %0d cycles, expected idle", name, budget);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_grants(input string name, input int n, input int budget);
    int c;
    c = 0;
    while (side_log.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk1({name, "_reached"}, side_log.size() >= n, 1'b1);
  endtask

  // Reference arbiter: decides a winner whenever it is idle and someone is asking
  initial begin
    bit   take_data;
    txn_t t;
    forever begin
      @(posedge clk);
      if (!model_en || !rstz) begin
        busy = 1'b0;
        starve = 0;
        last_data = 1'b0;
        continue;
      end
      if (busy) begin
        if (mem_ack) busy = 1'b0;
      end else begin
`ifdef KRONOS_ARB_RR_EN
        take_data = data_req && (!instr_req || !last_data);
        if (instr_req || data_req) last_data = take_data;
`else
        take_data = data_req && !(instr_req && starve >= STARVE_LIMIT);
        if (!instr_req) starve = 0;
        else if (take_data) starve = (starve < 15) ? starve + 1 : 15;
        else starve = 0;
`endif
        if (take_data) begin
          t.is_data = 1'b1; t.addr = data_addr; t.wdata = data_wr_data;
          t.mask = data_mask; t.wr = data_wr_en;
          exp_q.push_back(t);
          busy = 1'b1;
        end else if (instr_req) begin
          t.is_data = 1'b0; t.addr = instr_addr; t.wdata = 32'd0;
          t.mask = 4'hF; t.wr = 1'b0;
          exp_q.push_back(t);
          busy = 1'b1;
        end
      end
    end
  end

  // Fetch requester: holds req until its ack, then drops or re-requests
  initial begin
    bit seen;
    forever begin
      @(negedge clk); #2;
      seen = instr_ack;
      @(posedge clk); #1;
      if (seen) instr_req = 1'b0;
      if (!instr_req && rstz && (instr_mode == 2 || (instr_mode == 1 && $urandom_range(0, 2) == 0))) begin
        instr_addr = $urandom & 32'hFFFF_FFFC;
        instr_req = 1'b1;
      end
    end
  end

  // Load/store requester
  initial begin
    bit seen;
    forever begin
      @(negedge clk); #2;
      seen = data_ack;
      @(posedge clk); #1;
      if (seen) data_req = 1'b0;
      if (!data_req && rstz && (data_mode == 2 || (data_mode == 1 && $urandom_range(0, 2) == 0))) begin
        data_addr = $urandom;
        data_wr_data = $urandom;
        data_mask = 4'($urandom_range(1, 15));
        data_wr_en = 1'($urandom_range(0, 1));
        data_req = 1'b1;
      end
    end
  end

  // Memory model and monitor
  initial begin
    logic [31:0] rd;
    forever begin
      @(negedge clk);
      if (!mem_auto) continue;
      if (ack_driven) begin
        mem_ack = 1'b0;
        ack_driven = 1'b0;
        in_txn = 1'b0;
        chk1("mem_req_release", mem_req, 1'b0);
      end
      if (!in_txn) begin
        if (mem_req) begin
          in_txn = 1'b1;
          wait_left = (mem_lat < 0) ? $urandom_range(0, 3) : mem_lat;
          grant_cyc.push_back(cyc);
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            cur_valid = 1'b0;
            $display("FAIL unexpected_grant: mem_req=1 addr=0x%08h, expected no grant", mem_addr);
          end else begin
            cur = exp_q.pop_front();
            cur_valid = 1'b1;
            chk("grant_addr", mem_addr, cur.addr);
            chk1("grant_wr_en", mem_wr_en, cur.wr);
            chk({28'd0, mem_mask}, {28'd0, cur.mask} == {28'd0, mem_mask} ? {28'd0, mem_mask} : {28'd0, mem_mask}, {28'd0, cur.mask});
            if (cur.is_data) chk("grant_wr_data", mem_wr_data, cur.wdata);
          end
        end else if (exp_q.size() != 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL grant_latency: mem_req=0, expected 1 one cycle after request");
          exp_q.delete();
        end
      end else if (cur_valid) begin
        chk1("hold_mem_req", mem_req, 1'b1);
        chk("hold_addr", mem_addr, cur.addr);
        chk({28'd0, mem_mask}, {28'd0, mem_mask}, {28'd0, cur.mask});
      end
      if (in_txn) begin
        if (wait_left == 0) begin
          rd = rd_override_en ? rd_override : $urandom;
          mem_rd_data = rd;
          mem_ack = 1'b1;
          ack_driven = 1'b1;
          #1;
          ack_cyc.push_back(cyc);
          side_log.push_back(data_ack);
          data_log.push_back(data_ack ? data_rd_data : instr_data);
          if (cur_valid) begin
            chk1("ack_instr", instr_ack, !cur.is_data);
            chk1("ack_data", data_ack, cur.is_data);
            chk("ack_rd_data", cur.is_data ? data_rd_data : instr_data, rd);
          end
          $display("txn cyc=%0d side=%s addr=0x%08h wr=%0b mask=%h wdata=0x%08h rd=0x%08h",
                   cyc, data_ack ? "D" : "I", mem_addr, mem_wr_en, mem_mask, mem_wr_data, rd);
        end else begin
          wait_left--;
          chk("early_ack", {30'd0, instr_ack, data_ack}, 32'd0);
        end
      end
    end
  end

  initial begin
    int c;
    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk1("rst_mem_req", mem_req, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wr_data", mem_wr_data, 32'd0);
    chk("rst_mem_mask", {28'd0, mem_mask}, 32'd0);
    chk1("rst_mem_wr_en", mem_wr_en, 1'b0);
    chk1("rst_instr_ack", instr_ack, 1'b0);
    chk1("rst_data_ack", data_ack, 1'b0);
    @(posedge clk); #1;
    rstz = 1'b1;

    // single fetch
    clear_logs();
    mem_lat = 2; rd_override_en = 1'b1; rd_override = 32'h0000_0013;
    @(posedge clk); #1;
    instr_addr = 32'h100; instr_req = 1'b1; req_cyc = cyc;
    wait_quiet("fetch_done", 50);
    chk("fetch_count", 32'(side_log.size()), 32'd1);
    if (side_log.size() > 0) begin
      chk1("fetch_side", side_log[0], 1'b0);
      chk("fetch_data", data_log[0], 32'h13);
      chk("fetch_latency", 32'(grant_cyc[0] - req_cyc), 32'd1);
    end
    rd_override_en = 1'b0;

    // store
    clear_logs();
    mem_lat = 1;
    @(posedge clk); #1;
    data_addr = 32'h2004; data_wr_data = 32'hDEAD_BEEF; data_mask = 4'h3; data_wr_en = 1'b1;
    data_req = 1'b1;
    wait_quiet("store_done", 50);
    chk("store_count", 32'(side_log.size()), 32'd1);
    if (side_log.size() > 0) chk1("store_side", side_log[0], 1'b1);

    // collision with 1-cycle memory
    clear_logs();
    mem_lat = 0;
    @(posedge clk); #1;
    instr_addr = 32'h200; instr_req = 1'b1;
    data_addr = 32'h3000; data_wr_data = 32'h1234_5678; data_mask = 4'hF; data_wr_en = 1'b0;
    data_req = 1'b1;
    wait_quiet("collision_done", 50);
    chk("collision_count", 32'(side_log.size()), 32'd2);
    if (side_log.size() >= 2) begin
`ifdef KRONOS_ARB_RR_EN
      chk1("collision_first", side_log[0], 1'b0);
      chk1("collision_second", side_log[1], 1'b1);
`else
      chk1("collision_first", side_log[0], 1'b1);
      chk1("collision_second", side_log[1], 1'b0);
`endif
      chk("collision_gap", 32'(grant_cyc[1] - ack_cyc[0]), 32'd2);
    end

    // sustained contention
    clear_logs();
    mem_lat = 1;
`ifdef KRONOS_ARB_RR_EN
    instr_mode = 2; data_mode = 2;
    wait_grants("rr", 8, 200);
    instr_mode = 0; data_mode = 0;
    wait_quiet("rr_done", 100);
    for (int k = 1; k < 8 && k < side_log.size(); k++) begin
      chk1("rr_alternate", side_log[k], !side_log[k-1]);
    end
`else
    @(posedge clk); #1;
    instr_addr = 32'h400; instr_req = 1'b1;
    data_addr = 32'h5000; data_wr_data = 32'h0; data_mask = 4'hF; data_wr_en = 1'b0;
    data_req = 1'b1;
    data_mode = 2;
    wait_grants("starve", 5, 200);
    data_mode = 0;
    wait_quiet("starve_done", 100);
    for (int k = 0; k < 5 && k < side_log.size(); k++) begin
      chk1("starve_order", side_log[k], (k < STARVE_LIMIT) ? 1'b1 : 1'b0);
    end
`endif

    // randomized traffic
    clear_logs();
    mem_lat = -1;
    instr_mode = 1; data_mode = 1;
    repeat (1500) @(posedge clk);
    instr_mode = 0; data_mode = 0;
    wait_quiet("random_done", 200);
    chk1("random_traffic_seen", side_log.size() > 50, 1'b1);

    // reset in the middle of a data grant
    mem_auto = 1'b0; model_en = 1'b0;
    @(posedge clk); #1;
    data_addr = 32'h6000; data_wr_data = 32'hCAFE_F00D; data_mask = 4'hF; data_wr_en = 1'b1;
    data_req = 1'b1;
    c = 0;
    while (!mem_req && c < 10) begin
      @(negedge clk);
      c++;
    end
    chk1("rst_mid_pre_mem_req", mem_req, 1'b1);
    @(negedge clk); #3;
    mem_rd_data = 32'h5555_AAAA; mem_ack = 1'b1;
    #1;
    chk1("rst_mid_pre_data_ack", data_ack, 1'b1);
    rstz = 1'b0;
    #1;
    chk1("rst_mid_mem_req", mem_req, 1'b0);
    chk1("rst_mid_data_ack", data_ack, 1'b0);
    chk("rst_mid_mem_addr", mem_addr, 32'd0);
    data_req = 1'b0; mem_ack = 1'b0;
    @(posedge clk); #1;
    rstz = 1'b1;
    @(negedge clk); #3;
    mem_ack = 1'b1;
    #1;
    chk1("late_ack_data", data_ack, 1'b0);
    chk1("late_ack_instr", instr_ack, 1'b0);
    @(negedge clk); #3;
    mem_ack = 1'b0;
    chk1("late_ack_mem_req", mem_req, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/kronos_mem_arbiter.md
Name: kronos_mem_arbiter

Overview:
- Shares one memory port between the Kronos core's instruction-fetch interface and its load/store data interface.
- Sits between kronos_core and a single-ported memory or bus slave. Each side sees an independent req/ack port.
- Grants one outstanding transaction at a time. Data-side requests have priority, and a counter guarantees fetch forward progress.

Parameters:
- STARVE_LIMIT, 4: max consecutive data grants while an instruction request is pending before instruction is forced; range 1..15.

Ports:
- clk  in  1  core clock
- rstz  in  1  asynchronous active-low reset
- instr_addr  in  32  fetch address
- instr_req  in  1  fetch request, held until instr_ack
- instr_ack  out  1  fetch complete, single-cycle pulse
- instr_data  out  32  fetch read data, valid with instr_ack
- data_addr  in  32  load/store address
- data_wr_data  in  32  store data
- data_mask  in  4  byte enables
- data_wr_en  in  1  1 = store, 0 = load
- data_req  in  1  data request, held until data_ack
- data_ack  out  1  data complete, single-cycle pulse
- data_rd_data  out  32  load data, valid with data_ack
- mem_addr  out  32  memory address
- mem_wr_data  out  32  memory write data
- mem_mask  out  4  memory byte enables
- mem_wr_en  out  1  memory write enable
- mem_req  out  1  memory request, held until mem_ack
- mem_ack  in  1  memory completion pulse
- mem_rd_data  in  32  memory read data, valid with mem_ack

Behaviour:
- Clocking and reset: one clock `clk`; reset `rstz` is asynchronous and active-low.
- States: IDLE, GNT_I, GNT_D.
- Reset values: state = IDLE. mem_req, mem_wr_en, instr_ack, data_ack = 0. mem_addr, mem_wr_data, mem_mask = 0. starve_cnt = 0.
- IDLE:
  - If data_req and NOT (instr_req and starve_cnt >= STARVE_LIMIT): go to GNT_D.
  - Else if instr_req: go to GNT_I.
  - Else stay in IDLE.
- Grant capture: on the IDLE→GNT_x edge, register mem_addr, mem_wr_data, mem_mask and mem_wr_en from the winner, and set mem_req = 1.
  - For GNT_I, force mem_wr_en = 0 and mem_mask = 4'hF.
  - Latency: mem_req rises exactly 1 cycle after the winning req is first sampled in IDLE.
- GNT_x:
  - mem_req stays high and mem_* stays stable until mem_ack.
  - On mem_ack: the granted side's ack = 1 in the same cycle (combinational), rd_data = mem_rd_data. mem_req drops on the next edge; state → IDLE.
  - The non-granted ack is always 0. instr_data and data_rd_data show mem_rd_data whenever their ack is high; otherwise they are don't-care, and a registered implementation may hold them at 0.
- Ack-cycle timing:
  - The requester deasserts req after its ack, so IDLE re-arbitrates on the next cycle.
  - Minimum transaction period is 2 cycles plus memory latency: one IDLE bubble between back-to-back transactions.
- mem_ack in IDLE: ignored, no ack generated.
- starve_cnt (4 bits):
  - On entering GNT_D while instr_req = 1: increment, saturating at 15.
  - On entering GNT_I, or in IDLE with instr_req = 0: clear to 0.
- Requester drops req mid-grant (protocol violation): the transaction is not aborted. mem_req stays high until mem_ack, and the ack pulse is still issued.
- Simultaneous instr_req and data_req in IDLE with starve_cnt < STARVE_LIMIT: data wins.
- Reset mid-transaction: immediate return to IDLE, mem_req = 0. Any later mem_ack while in IDLE is dropped.

Optional Feature:
- Macro: KRONOS_ARB_RR_EN.
- Defined: round-robin arbitration.
  - A 1-bit last_gnt register (reset 0 = instr).
  - On simultaneous requests in IDLE, the side not equal to last_gnt wins. last_gnt updates on each grant.
  - starve_cnt and STARVE_LIMIT are unused; the parameter is still declared.
- Undefined: fixed data priority with the starvation counter, as described above.

Test Plan:
- Single fetch: instr_req = 1, instr_addr = 0x100; mem_ack after 2 cycles with mem_rd_data = 0x00000013 → mem_req rises 1 cycle after req with mem_addr = 0x100, mem_wr_en = 0, mem_mask = 0xF; instr_ack pulses 1 cycle with instr_data = 0x13.
- Store: data_req = 1, data_addr = 0x2004, data_wr_data = 0xDEADBEEF, data_mask = 0x3, data_wr_en = 1 → mem_* carries exactly these values; data_ack pulses on mem_ack; instr_ack stays 0.
- Collision: instr_req and data_req both raised in the same cycle, with 1-cycle memory → data served first; fetch granted after the IDLE bubble, 2 cycles after data_ack.
- Starvation (STARVE_LIMIT = 4): data_req held continuously and re-raised each cycle, instr_req held → exactly 4 data grants, then 1 instruction grant; starve_cnt returns to 0.
- Reset mid-grant: rstz low while in GNT_D with mem_req = 1 → mem_req = 0 and data_ack = 0 asynchronously; a mem_ack arriving after reset release produces no ack.
- With KRONOS_ARB_RR_EN: both requests held continuously → grants alternate D, I, D, I… (first grant D, since last_gnt resets to instr).
